fpu_f2i_converter: RTL

- Multi-cycle FCVT.W.S / FCVT.WU.S unit in the FPU of the execution unit.
- Converts an IEEE-754 single-precision operand to a signed or unsigned 32-bit integer.
- This is the float-to-integer direction, complementary to the leading-one normalisation path used on the int-to-float side.
- An iterative right shifter, bounded to SHIFT_STEP bits per cycle, produces the integer part with guard/sticky bits; a rounding stage then applies RISC-V rounding, saturation and fflags.

---
 rtl/fpu_f2i_converter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_f2i_converter.sv
// rtl/fpu_f2i_converter.sv - multi-cycle FCVT.W.S / FCVT.WU.S float-to-integer converter
// Iterative right shifter (SHIFT_STEP bits/cycle) followed by a single RISC-V rounding/saturation cycle.
module fpu_f2i_converter #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic        unsigned_op,
  input  logic [2:0]  rm,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_nx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  localparam logic [4:0] STEP    = 5'(SHIFT_STEP);
  localparam logic [4:0] REM_MAX = 5'd26;

  logic [1:0]  state_q, state_d;
  logic [31:0] int_q, int_d;
  logic        g_q, g_d;
  logic        sb_q, sb_d;
  logic [4:0]  rem_q, rem_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic        sat_q, sat_d;
  logic        sat_neg_q, sat_neg_d;
  logic [31:0] res_q, res_d;
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;
  logic        done_q, done_d;

  // Operand decode for the load cycle
  logic        ld_s;
  logic [7:0]  ld_e;
  logic [22:0] ld_f;
  logic [23:0] ld_m;
  logic        ld_nan;
  logic        ld_sat;
  logic        ld_big;
  logic [7:0]  ld_diff;
  logic [4:0]  ld_rem;
  logic [31:0] ld_int;

  assign ld_s    = op_a[31];
  assign ld_e    = op_a[30:23];
  assign ld_f    = op_a[22:0];
  assign ld_m    = {(ld_e != 8'd0), ld_f};
  assign ld_nan  = (ld_e == 8'd255) && (ld_f != 23'd0);
  assign ld_sat  = (ld_e >= 8'd159);
  assign ld_big  = (ld_e >= 8'd150);
  assign ld_diff = 8'd150 - ld_e;

  always_comb begin
    ld_int = {8'd0, ld_m};
    ld_rem = 5'd0;
    if (ld_sat) begin
      ld_int = 32'd0;
    end else if (ld_big) begin
      ld_int = {8'd0, ld_m} << (ld_e - 8'd150);
    end else begin
      ld_rem = (ld_diff > 8'd26) ? REM_MAX : ld_diff[4:0];
    end
  end

  // One shift step of k bits; the bit just below the new LSB becomes guard
  logic [4:0]  sh_k;
  logic [4:0]  sh_km1;
  logic [31:0] sh_pre;
  logic [31:0] sh_mask;
  logic        sh_g;
  logic        sh_sb;
  logic [31:0] sh_int;
  logic [4:0]  sh_rem;

  assign sh_k    = (rem_q < STEP) ? rem_q : STEP;
  assign sh_km1  = sh_k - 5'd1;
  assign sh_pre  = int_q >> sh_km1;
  assign sh_mask = (32'd1 << sh_km1) - 32'd1;
  assign sh_g    = sh_pre[0];
  assign sh_sb   = sb_q | g_q | (|(int_q & sh_mask));
  assign sh_int  = sh_pre >> 1;
  assign sh_rem  = rem_q - sh_k;

  // Rounding increment and saturation
  logic        rnd_inc;
  logic [32:0] rnd_mag;
  logic [31:0] rnd_res;
  logic        rnd_nv;
  logic        rnd_nx;

  always_comb begin
    case (rm_q)
      3'b001:  rnd_inc = 1'b0;
      3'b010:  rnd_inc = sign_q & (g_q | sb_q);
      3'b011:  rnd_inc = ~sign_q & (g_q | sb_q);
      3'b100:  rnd_inc = g_q;
      default: rnd_inc = g_q & (sb_q | int_q[0]);
    endcase
  end

  assign rnd_mag = {1'b0, int_q} + {32'd0, rnd_inc};

  always_comb begin
    rnd_res = 32'd0;
    rnd_nv  = 1'b0;
    if (sat_q) begin
      rnd_nv = 1'b1;
      if (uns_q) begin
        rnd_res = sat_neg_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
      end else begin
        rnd_res = sat_neg_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (uns_q) begin
      if (rnd_mag > 33'h0_FFFF_FFFF) begin
        rnd_res = 32'hFFFF_FFFF;
        rnd_nv  = 1'b1;
      end else if (sign_q && (rnd_mag != 33'd0)) begin
        rnd_res = 32'h0000_0000;
        rnd_nv  = 1'b1;
      end else begin
        rnd_res = rnd_mag[31:0];
      end
    end else begin
      if (!sign_q && (rnd_mag > 33'h0_7FFF_FFFF)) begin
        rnd_res = 32'h7FFF_FFFF;
        rnd_nv  = 1'b1;
      end else if (sign_q && (rnd_mag > 33'h0_8000_0000)) begin
        rnd_res = 32'h8000_0000;
        rnd_nv  = 1'b1;
      end else begin
        rnd_res = sign_q ? (32'd0 - rnd_mag[31:0]) : rnd_mag[31:0];
      end
    end
    rnd_nx = rnd_nv ? 1'b0 : (g_q | sb_q);
  end

  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    g_d       = g_q;
    sb_d      = sb_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    uns_d     = uns_q;
    rm_d      = rm_q;
    sat_d     = sat_q;
    sat_neg_d = sat_neg_q;
    res_d     = res_q;
    nv_d      = nv_q;
    nx_d      = nx_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          int_d     = ld_int;
          g_d       = 1'b0;
          sb_d      = 1'b0;
          rem_d     = ld_rem;
          sign_d    = ld_s;
          uns_d     = unsigned_op;
          rm_d      = rm;
          sat_d     = ld_sat;
          sat_neg_d = ld_s & ~ld_nan;
          state_d   = (ld_rem != 5'd0) ? S_SHIFT : S_ROUND;
        end
      end
      S_SHIFT: begin
        int_d = sh_int;
        g_d   = sh_g;
        sb_d  = sh_sb;
        rem_d = sh_rem;
        if (sh_rem == 5'd0) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d   = rnd_res;
        nv_d    = rnd_nv;
        nx_d    = rnd_nx;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      int_q     <= 32'd0;
      g_q       <= 1'b0;
      sb_q      <= 1'b0;
      rem_q     <= 5'd0;
      sign_q    <= 1'b0;
      uns_q     <= 1'b0;
      rm_q      <= 3'd0;
      sat_q     <= 1'b0;
      sat_neg_q <= 1'b0;
      res_q     <= 32'd0;
      nv_q      <= 1'b0;
      nx_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      g_q       <= g_d;
      sb_q      <= sb_d;
      rem_q     <= rem_d;
      sign_q    <= sign_d;
      uns_q     <= uns_d;
      rm_q      <= rm_d;
      sat_q     <= sat_d;
      sat_neg_q <= sat_neg_d;
      res_q     <= res_d;
      nv_q      <= nv_d;
      nx_q      <= nx_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign result  = res_q;
  assign flag_nv = nv_q;
  assign flag_nx = nx_q;

endmodule
